// File: rtl/rf_pkg.sv
// Shared constants, FSM state encoding and a width helper for the
// register-file writeback arbiter.
package rf_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 16;
  localparam int RF_DEPTH = 16;

  typedef enum logic [0:0] {
    ST_INIT_CLR = 1'b0,
    ST_ARB      = 1'b1
  } state_e;

  // Index width that stays at least one bit, so NREQ=1 still has a
  // legal grant_id port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after
// ptr wins, wrapping back to index 0. The caller owns the pointer.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  // Two passes (upper range from ptr, then the wrapped lower range)
  // keep every index a loop constant instead of a modulo expression.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register file's single write port. After reset an
// optional sweep zeroes every register, then NREQ writeback requesters
// share the port through valid/ready with round-robin priority.
// Optional build macro RF_ZERO_REG_PROTECT_EN: accepted requests to
// address 0 are dropped from the write port so register 0 reads as zero.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DW         = RF_DW,
  parameter int AW         = RF_AW,
  parameter int INIT_CLEAR = 1,
  localparam int GW        = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        Rd,
  output logic [DW-1:0]        RW,
  output logic                 wr,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  state_e          state;
  logic [AW-1:0]   clr_cnt;
  logic [GW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [GW-1:0]   gnt_idx;
  logic            xfer;
  logic            wr_en;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.N(NREQ), .IW(GW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants exist only while arbitrating and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == ST_ARB && !rst) req_ready = gnt;
    xfer     = |req_ready;
    sel_rd   = req_rd[int'(gnt_idx)*AW +: AW];
    sel_data = req_data[int'(gnt_idx)*DW +: DW];
`ifdef RF_ZERO_REG_PROTECT_EN
    wr_en    = xfer && (sel_rd != '0);
`else
    wr_en    = xfer;
`endif
  end

  assign busy = (state == ST_INIT_CLR);

  // Sweep counter, round-robin pointer and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (INIT_CLEAR != 0) ? ST_INIT_CLR : ST_ARB;
      clr_cnt  <= '0;
      rr_ptr   <= '0;
      wr       <= 1'b0;
      Rd       <= '0;
      RW       <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        ST_INIT_CLR: begin
          wr      <= 1'b1;
          Rd      <= clr_cnt;
          RW      <= '0;
          clr_cnt <= clr_cnt + AW'(1);
          if (&clr_cnt) state <= ST_ARB;
        end
        default: begin
          wr <= wr_en;
          if (xfer) begin
            Rd       <= sel_rd;
            RW       <= sel_data;
            grant_id <= gnt_idx;
            rr_ptr   <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + GW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Stimulus pushes every expected
// write-port transaction into a queue; a negedge monitor pops and
// compares whenever wr is presented.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int GW   = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*AW-1:0]  req_rd    = '0;
  logic [NREQ*DW-1:0]  req_data  = '0;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       Rd;
  logic [DW-1:0]       RW;
  logic                wr;
  logic [GW-1:0]       grant_id;
  logic                busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW+DW+GW-1:0] exp_q[$];

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .Rd(Rd), .RW(RW),
    .wr(wr), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [GW-1:0] g);
    exp_q.push_back({a, d, g});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every presented write must match the queue head.
  always @(negedge clk) begin
    if (rst && wr) begin
      n_chk++; n_fail++;
      $display("FAIL wr_in_reset: got wr=1 expected wr=0");
    end else if (!rst && wr) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got Rd=%h RW=%h gid=%h expected none", Rd, RW, grant_id);
      end else begin
        chk("write_port", {11'd0, Rd, RW, grant_id}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_wr", wr, 0);
    chk("rst_rd", Rd, 0);
    chk("rst_rw", RW, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);

    // partial sweep, reset while Rd=7 is on the port
    for (int i = 0; i < 7; i++) exp_wr(AW'(i), '0, '0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("sweep7_rd", Rd, 7);
    chk("sweep7_wr", wr, 1);
    rst = 1'b1;
    #1;
    chk("midrst_wr", wr, 0);
    chk("midrst_rd", Rd, 0);
    chk("midrst_busy", busy, 1);
    tick();

    // full sweep with r1 already pending
    req_valid = 2'b10;
    req_rd    = {4'd5, 4'd0};
    req_data  = {16'h5555, 16'h0000};
    for (int i = 0; i < 16; i++) exp_wr(AW'(i), '0, '0);
    exp_wr(4'd5, 16'h5555, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("sweep_busy0", busy, 1);
    chk("sweep_ready0", req_ready, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15) begin
        chk("sweep_busy", busy, 1);
        chk("sweep_ready", req_ready, 0);
      end else begin
        chk("sweep_done_busy", busy, 0);
        chk("first_arb_ready", req_ready, 2'b10);
      end
    end
    tick();
    req_valid = '0;
    tick();
    chk("idle_wr", wr, 0);
    chk("hold_rd", Rd, 5);
    chk("hold_rw", RW, 16'h5555);
    chk("hold_gid", grant_id, 1);

    // r0 alone (rr_ptr now 0)
    req_valid = 2'b01;
    req_rd    = {4'd0, 4'd3};
    req_data  = {16'h0000, 16'hA5A5};
    exp_wr(4'd3, 16'hA5A5, 1'b0);
    #1;
    chk("r0_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;

    // r1 alone brings rr_ptr back to 0
    req_valid = 2'b10;
    req_rd    = {4'd9, 4'd0};
    req_data  = {16'h9999, 16'h0000};
    exp_wr(4'd9, 16'h9999, 1'b1);
    tick();
    req_valid = '0;

    // both continuous: grants 0,1,0,1
    req_valid = 2'b11;
    req_rd    = {4'd2, 4'd1};
    req_data  = {16'h2222, 16'h1111};
    for (int k = 0; k < 4; k++)
      if (k % 2 == 0) exp_wr(4'd1, 16'h1111, 1'b0);
      else            exp_wr(4'd2, 16'h2222, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr_wr", wr, 1);
    end
    req_valid = '0;

    // same destination from both: arbitration order, last one wins
    req_valid = 2'b11;
    req_rd    = {4'd4, 4'd4};
    req_data  = {16'hBBBB, 16'hAAAA};
    exp_wr(4'd4, 16'hAAAA, 1'b0);
    exp_wr(4'd4, 16'hBBBB, 1'b1);
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = '0;

    // address 0 request
    req_valid = 2'b01;
    req_rd    = {4'd0, 4'd0};
    req_data  = {16'h0000, 16'hFFFF};
`ifndef RF_ZERO_REG_PROTECT_EN
    exp_wr(4'd0, 16'hFFFF, 1'b0);
`endif
    #1;
    chk("rd0_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
`ifdef RF_ZERO_REG_PROTECT_EN
    chk("rd0_wr", wr, 0);
`else
    chk("rd0_wr", wr, 1);
    chk("rd0_rw", RW, 16'hFFFF);
`endif

    // pointer advanced past r0 even for the address-0 request
    req_valid = 2'b11;
    req_rd    = {4'd6, 4'd7};
    req_data  = {16'h6666, 16'h7777};
    exp_wr(4'd6, 16'h6666, 1'b1);
    exp_wr(4'd7, 16'h7777, 1'b0);
    #1;
    chk("ptr_adv_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = '0;

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (Rd, RW, wr) of the 16 x 16-bit register file.
- Shares that port between NREQ writeback requesters (ALU, load unit, ...) using valid/ready handshakes and round-robin priority.
- After every reset, a built-in sweep writes zero to all 16 registers before any request is accepted.
- Outputs are registered and drive the register file's Rd/RW/wr inputs directly.

Parameters:
- NREQ, 2, number of write requesters (>=1).
- DW, 16, data width.
- AW, 4, register address width; depth = 2**AW.
- INIT_CLEAR, 1, 1 = run the zero sweep after reset; 0 = go straight to arbitration.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_rd  in  NREQ*AW  destination address; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*DW  write data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant, combinational in ARB.
- Rd  out  AW  registered write address to the register file.
- RW  out  DW  registered write data to the register file.
- wr  out  1  registered write enable to the register file.
- grant_id  out  max(1,clog2(NREQ))  registered index of the requester behind the current wr.
- busy  out  1  high while the zero sweep runs.

Behaviour:
- Reset (asynchronous, rst=1):
  - State = INIT_CLR if INIT_CLEAR=1, else ARB.
  - clr_cnt=0, rr_ptr=0.
  - wr=0, Rd=0, RW=0, grant_id=0.
  - busy = INIT_CLEAR.
  - req_ready=0 while rst is high.
- INIT_CLR state:
  - req_ready=0 on all requesters.
  - Each cycle registers wr=1, Rd=clr_cnt, RW=0, then increments clr_cnt.
  - Transitions to ARB after the write with Rd=2**AW-1, i.e. exactly 16 write cycles at default parameters.
  - busy drops in the same cycle the last clear write is presented.
  - req_valid is ignored during the sweep; requests stay pending.
- ARB state, round-robin selection:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - req_ready is one-hot on the winner and all-zero when nothing is valid.
  - Transfer happens on a clock edge where req_valid[i] & req_ready[i].
- ARB state, on a transfer (next edge):
  - wr=1, Rd=req_rd[i], RW=req_data[i], grant_id=i.
  - rr_ptr = (i+1) mod NREQ.
  - Latency: request accepted at edge N appears on the write port after edge N; the register file commits at edge N+1.
- ARB state, with no transfer:
  - wr=0.
  - Rd, RW, grant_id hold their previous values.
  - rr_ptr holds.
- Requester rules:
  - A requester keeps valid, rd and data stable until it sees ready; dropping valid before ready is legal and cancels the request.
  - ready never depends on the requester's own data.
- Throughput: one write per cycle. Under continuous requests from all requesters, each requester is granted at least once every NREQ cycles.
- NREQ=1: req_ready = req_valid in ARB; rr_ptr is constant 0.
- Simultaneous requests to the same Rd from different requesters are both performed, in arbitration order; the last granted write wins.
- Reset mid-sweep or mid-transfer: any pending write is discarded (wr=0 immediately) and the sweep restarts from address 0.
- The block never asserts wr while rst is high.

Optional Feature:
- Macro: RF_ZERO_REG_PROTECT_EN.
- Defined: a granted request with Rd==0 is still accepted (ready, rr_ptr advances), but the registered wr stays 0, so register 0 stays hardwired to zero. The zero sweep still writes address 0.
- Undefined: address 0 is written like any other register.

Decomposition:
- Shared package rf_pkg holds:
  - RF_AW=4, RF_DW=16, RF_DEPTH=16.
  - The state enum {ST_INIT_CLR, ST_ARB}.
  - Function clog2_min1.
- Sub-module rr_arbiter, parameter N, combinational:
  - Inputs: req[N], ptr.
  - Outputs: gnt one-hot, gnt_idx.
  - The top level owns rr_ptr and all registers.

Test Plan:
- Reset, INIT_CLEAR=1, no requests -> busy high for 16 cycles; wr=1 with Rd=0..15 consecutively and RW=0; req_ready=0 throughout; then busy=0, wr=0.
- After the sweep, requester 0 alone sends Rd=3, data=16'hA5A5 -> req_ready[0]=1 in that cycle; next cycle wr=1, Rd=3, RW=16'hA5A5, grant_id=0.
- Both requesters valid continuously (r0: Rd=1, 16'h1111; r1: Rd=2, 16'h2222), rr_ptr=0 -> grants alternate 0,1,0,1; wr high every cycle.
- Assert rst in the sweep cycle writing Rd=7 -> wr=0 immediately; after release, the sweep restarts at Rd=0 and runs all 16 cycles.
- With RF_ZERO_REG_PROTECT_EN, request Rd=0, data=16'hFFFF -> req_ready=1, wr stays 0, rr_ptr advances. Without the macro -> wr=1, Rd=0, RW=16'hFFFF.
- r1 valid during the sweep -> no ready until ARB; first ARB cycle req_ready[1]=1; the write appears one cycle later.
